// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction field widths, fetch FSM states.
// Imported by the fetch sequencer, its interface and the testbench.
package cpu_pkg;

    localparam int OPC_W = 4;
    localparam int OPD_W = 4;

    localparam logic [OPC_W-1:0] OP_HALT  = 4'b0000;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'b0010;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'b0110;
    localparam logic [OPC_W-1:0] OP_STORE = 4'b0111;
    localparam logic [OPC_W-1:0] OP_JUMP  = 4'b1111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_JTGT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction-memory req/ack port plus the opcode valid/ready port.
// master = fetch sequencer side, slave = memory/decoder side.
interface instr_fetch_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [7:0]        imem_rdata;
    logic [OPC_W-1:0]  opcode;
    logic [OPD_W-1:0]  operand;
    logic [ADDR_W-1:0] pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              halted;

    modport master (
        output imem_req, imem_addr, opcode, operand, pc, instr_valid, halted,
        input  imem_ack, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, opcode, operand, pc, instr_valid, halted,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Purpose: fetches instruction bytes, splits opcode/operand, resolves two-byte JUMPs; IFETCH_HALT_EN makes 4'b0000 a HALT.
// Latency: ack -> instr_valid next cycle; byte-1 ack of a JUMP -> byte-2 request next cycle; handshake -> next request next cycle.
// Backpressure: outputs held in ISSUE until instr_ready; no fetch overlaps ISSUE (one instruction in flight).
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    localparam logic [1:0] S_FETCH = ST_FETCH;
    localparam logic [1:0] S_JTGT  = ST_JTGT;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
`ifdef IFETCH_HALT_EN
    localparam logic [1:0] S_HALT  = ST_HALT;
`endif

    logic [$bits(fetch_state_e)-1:0] state;
    logic [ADDR_W-1:0]               fetch_pc;
    logic [ADDR_W-1:0]               jump_tgt;
    logic [ADDR_W-1:0]               next_pc;
    logic                            is_jump;
    logic                            ack_ok;
    logic                            issue_hs;

    // An ack only counts against a request we are actually holding.
    assign ack_ok   = bus.imem_req & bus.imem_ack;
    assign issue_hs = bus.instr_valid & bus.instr_ready;
    assign next_pc  = is_jump ? jump_tgt : fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_FETCH;
            fetch_pc        <= RESET_PC;
            jump_tgt        <= '0;
            is_jump         <= 1'b0;
            bus.imem_req    <= 1'b0;
            bus.imem_addr   <= RESET_PC;
            bus.opcode      <= '0;
            bus.operand     <= '0;
            bus.pc          <= RESET_PC;
            bus.instr_valid <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    bus.imem_req <= 1'b1;
                    if (ack_ok) begin
                        bus.pc      <= fetch_pc;
                        bus.operand <= bus.imem_rdata[3:0];
                        bus.opcode  <= bus.imem_rdata[7:4];
                        if (bus.imem_rdata[7:4] == OP_JUMP) begin
                            // Target byte follows the opcode byte; wraps past the top address.
                            bus.imem_addr <= fetch_pc + ADDR_W'(1);
                            state         <= S_JTGT;
                        end else begin
                            fetch_pc        <= fetch_pc + ADDR_W'(1);
                            is_jump         <= 1'b0;
                            bus.imem_req    <= 1'b0;
                            bus.instr_valid <= 1'b1;
                            state           <= S_ISSUE;
                        end
                    end
                end
                S_JTGT: begin
                    if (ack_ok) begin
                        jump_tgt        <= ADDR_W'(bus.imem_rdata);
                        is_jump         <= 1'b1;
                        bus.imem_req    <= 1'b0;
                        bus.instr_valid <= 1'b1;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_hs) begin
                        bus.instr_valid <= 1'b0;
                        fetch_pc        <= next_pc;
                        bus.imem_addr   <= next_pc;
`ifdef IFETCH_HALT_EN
                        if (bus.opcode == OP_HALT) begin
                            state <= S_HALT;
                        end else
`endif
                        begin
                            bus.imem_req <= 1'b1;
                            state        <= S_FETCH;
                        end
                    end
                end
`ifdef IFETCH_HALT_EN
                S_HALT: state <= S_HALT;
`endif
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef IFETCH_HALT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.halted <= 1'b0;
        end else if (state == S_ISSUE && issue_hs && bus.opcode == OP_HALT) begin
            bus.halted <= 1'b1;
        end
    end
`else
    assign bus.halted = 1'b0;
`endif

endmodule
